// File: rtl/pipeline_pkg.sv
// Shared types for the memory-port arbiter of the 5-stage RV32I pipeline.
//   arb_state_e : arbiter FSM state encoding
//   mem_req_t   : one memory-side command (write enable, address, data, byte mask)
//   arb_dbg_t   : debug snapshot of the arbiter (FSM state, owner, counters)
package pipeline_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam int MEM_BW = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_IF  = 2'd1,
    WAIT_LSU = 2'd2,
    RESP     = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [MEM_AW-1:0] addr;
    logic [MEM_DW-1:0] wdata;
    logic [MEM_BW-1:0] bmask;
  } mem_req_t;

  // Counters are zero-extended to 8 bits so the debug view does not
  // change shape when TIMEOUT or STARVE_LIMIT are retuned.
  typedef struct packed {
    arb_state_e state;
    logic       owner_lsu;
    logic [7:0] timeout_cnt;
    logic [7:0] starve_cnt;
  } arb_dbg_t;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Clear/enable saturating up-counter.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clr        : synchronous clear (wins over i_en)
//   i_en         : count up by one, holding at LIMIT
//   o_count      : current count
//   o_expired    : count has reached LIMIT
module arb_timeout_cnt #(
  parameter int LIMIT = 15,
  parameter int CW    = $clog2(LIMIT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_count,
  output logic          o_expired
);

  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_clr) begin
      cnt_q <= '0;
    end else if (i_en && (cnt_q != LIM)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign o_count   = cnt_q;
  assign o_expired = (cnt_q == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the IF stage
// and the MEM-stage LSU. One requester is granted at a time; the memory
// handshake has variable latency and is aborted after TIMEOUT wait cycles.
//
// Handshake: a requester raises *_req with stable address/data and holds it
// until its one-cycle *_ack; *_err qualifies *_ack. On the memory side
// o_mem_req rises on the grant edge, stays high (with stable command) up to
// and including the i_mem_ack cycle, and i_mem_ack is only honoured while
// the FSM is in a WAIT state.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_if_req/i_if_addr           fetch request
//   o_if_rdata/ack/err/stall     fetch response and stall to hazard unit
//   i_lsu_req/we/addr/wdata/bmask  load/store request
//   o_lsu_rdata/ack/err/stall    LSU response and stall to hazard unit
//   o_mem_req/we/addr/wdata/bmask  memory command
//   i_mem_rdata/i_mem_ack        memory response
//   o_dbg                        FSM state, owner and counter snapshot
module mem_port_arbiter
  import pipeline_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_ack,
  output logic          o_if_err,
  output logic          o_if_stall,
  input  logic          i_lsu_req,
  input  logic          i_lsu_we,
  input  logic [AW-1:0] i_lsu_addr,
  input  logic [DW-1:0] i_lsu_wdata,
  input  logic [3:0]    i_lsu_bmask,
  output logic [DW-1:0] o_lsu_rdata,
  output logic          o_lsu_ack,
  output logic          o_lsu_err,
  output logic          o_lsu_stall,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  output logic [3:0]    o_mem_bmask,
  input  logic [DW-1:0] i_mem_rdata,
  input  logic          i_mem_ack,
  output arb_dbg_t      o_dbg
);

  localparam int TO_W = $clog2(TIMEOUT);
  localparam int ST_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state_q, state_d;
  mem_req_t      mem_q;
  logic          mem_req_q;
  logic          owner_lsu_q;
  logic          err_q;
  logic [DW-1:0] if_rdata_q, lsu_rdata_q;

  logic          grant_if, grant_lsu;
  logic          in_wait, wait_done;
  logic          to_expired, starve_expired;
  logic [TO_W-1:0] to_count;
  logic [ST_W-1:0] starve_count;
  logic [DW-1:0] resp_rdata;

  // Expires when the count hits TIMEOUT-1: together with the cycle at
  // count 0 this gives exactly TIMEOUT wait cycles before the abort.
  arb_timeout_cnt #(
    .LIMIT (TIMEOUT - 1),
    .CW    (TO_W)
  ) u_timeout_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (grant_if | grant_lsu),
    .i_en      (in_wait),
    .o_count   (to_count),
    .o_expired (to_expired)
  );

  // Counts LSU wins taken while fetch was also waiting.
  arb_timeout_cnt #(
    .LIMIT (STARVE_LIMIT),
    .CW    (ST_W)
  ) u_starve_cnt (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (grant_if),
    .i_en      (grant_lsu & i_if_req),
    .o_count   (starve_count),
    .o_expired (starve_expired)
  );

  // LSU normally wins a tie; fetch wins once it has lost STARVE_LIMIT times.
  always_comb begin
    grant_if  = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == IDLE) begin
      if (i_lsu_req && !(i_if_req && starve_expired)) begin
        grant_lsu = 1'b1;
      end else if (i_if_req) begin
        grant_if = 1'b1;
      end
    end
  end

  assign in_wait   = (state_q == WAIT_IF) || (state_q == WAIT_LSU);
  assign wait_done = in_wait && (i_mem_ack || to_expired);
  // Stores and aborted accesses return zero; a real ack beats a timeout.
  assign resp_rdata = (i_mem_ack && !mem_q.we) ? i_mem_rdata : '0;

  // FSM: state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_lsu) begin
          state_d = WAIT_LSU;
        end else if (grant_if) begin
          state_d = WAIT_IF;
        end
      end
      WAIT_IF, WAIT_LSU: begin
        if (i_mem_ack || to_expired) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_if_ack  = 1'b0;
    o_lsu_ack = 1'b0;
    if (state_q == RESP) begin
      o_if_ack  = !owner_lsu_q;
      o_lsu_ack = owner_lsu_q;
    end
  end

  // Memory command and response capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_req_q   <= 1'b0;
      mem_q       <= '0;
      owner_lsu_q <= 1'b0;
      err_q       <= 1'b0;
      if_rdata_q  <= '0;
      lsu_rdata_q <= '0;
    end else if (grant_lsu) begin
      mem_req_q   <= 1'b1;
      owner_lsu_q <= 1'b1;
      mem_q.we    <= i_lsu_we;
      mem_q.addr  <= MEM_AW'(i_lsu_addr);
      mem_q.wdata <= MEM_DW'(i_lsu_wdata);
      mem_q.bmask <= i_lsu_we ? i_lsu_bmask : 4'h0;
    end else if (grant_if) begin
      mem_req_q   <= 1'b1;
      owner_lsu_q <= 1'b0;
      mem_q.we    <= 1'b0;
      mem_q.addr  <= MEM_AW'(i_if_addr);
      mem_q.wdata <= '0;
      mem_q.bmask <= 4'h0;
    end else if (wait_done) begin
      mem_req_q <= 1'b0;
      err_q     <= !i_mem_ack;
      if (state_q == WAIT_IF) begin
        if_rdata_q <= resp_rdata;
      end else begin
        lsu_rdata_q <= resp_rdata;
      end
    end
  end

  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_q.we;
  assign o_mem_addr  = AW'(mem_q.addr);
  assign o_mem_wdata = DW'(mem_q.wdata);
  assign o_mem_bmask = mem_q.bmask;

  assign o_if_rdata  = if_rdata_q;
  assign o_lsu_rdata = lsu_rdata_q;
  assign o_if_err    = o_if_ack & err_q;
  assign o_lsu_err   = o_lsu_ack & err_q;
  assign o_if_stall  = i_if_req & ~o_if_ack;
  assign o_lsu_stall = i_lsu_req & ~o_lsu_ack;

  always_comb begin
    o_dbg             = '0;
    o_dbg.state       = state_q;
    o_dbg.owner_lsu   = owner_lsu_q;
    o_dbg.timeout_cnt = 8'(to_count);
    o_dbg.starve_cnt  = 8'(starve_count);
  end

  // A requester that drops its request while being served breaks the
  // handshake; flag it in simulation.
  a_if_req_held : assert property (@(posedge i_clk) disable iff (i_rst)
    (state_q == WAIT_IF) |-> i_if_req);
  a_lsu_req_held : assert property (@(posedge i_clk) disable iff (i_rst)
    (state_q == WAIT_LSU) |-> i_lsu_req);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions
// followed by hand-written simultaneous, starvation, late-ack and reset
// sequences. A grant scoreboard checks the order of memory-side grants.
module tb_mem_port_arbiter;
  import pipeline_pkg::*;

  localparam int TO_CYC = 16;

  // ---------------- clock / reset ----------------
  logic tb_clk;
  logic tb_rst;

  initial begin
    tb_clk = 1'b0;
    forever #5 tb_clk = ~tb_clk;
  end

  // ---------------- DUT ----------------
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack, if_err, if_stall;
  logic        lsu_req, lsu_we;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [3:0]  lsu_bmask;
  logic [31:0] lsu_rdata;
  logic        lsu_ack, lsu_err, lsu_stall;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  arb_dbg_t    dbg;

  mem_port_arbiter dut (
    .i_clk       (tb_clk),
    .i_rst       (tb_rst),
    .i_if_req    (if_req),
    .i_if_addr   (if_addr),
    .o_if_rdata  (if_rdata),
    .o_if_ack    (if_ack),
    .o_if_err    (if_err),
    .o_if_stall  (if_stall),
    .i_lsu_req   (lsu_req),
    .i_lsu_we    (lsu_we),
    .i_lsu_addr  (lsu_addr),
    .i_lsu_wdata (lsu_wdata),
    .i_lsu_bmask (lsu_bmask),
    .o_lsu_rdata (lsu_rdata),
    .o_lsu_ack   (lsu_ack),
    .o_lsu_err   (lsu_err),
    .o_lsu_stall (lsu_stall),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_bmask (mem_bmask),
    .i_mem_rdata (mem_rdata),
    .i_mem_ack   (mem_ack),
    .o_dbg       (dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [32:0] exp_q[$];   // expected grants: {we, addr}

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  // Acks mem_lat cycles after o_mem_req rises (mem_lat < 0: never).
  logic [31:0] mem_model [logic [31:0]];
  int          mem_lat;
  logic        inject_ack;

  initial begin
    int idx;
    idx = -1;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge tb_clk);
      #1;
      if (mem_req) idx++;
      else idx = -1;
      mem_ack = 1'b0;
      mem_rdata = '0;
      if (inject_ack) begin
        mem_ack = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
      end else if (mem_req && mem_lat >= 1 && idx == mem_lat) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          logic [31:0] w;
          w = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
          for (int b = 0; b < 4; b++)
            if (mem_bmask[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
          mem_model[mem_addr] = w;
          mem_rdata = 32'hBAD0_BAD0;
        end else begin
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        end
      end
    end
  end

  // ---------------- grant scoreboard ----------------
  initial begin
    logic        prev;
    logic [32:0] e;
    prev = 1'b0;
    forever begin
      @(negedge tb_clk);
      if (mem_req && !prev) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_FFFF_FFFF;
        check("grant_order", {mem_we, mem_addr}, e);
      end
      prev = mem_req;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    bit          is_lsu;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bmask;
    int          lat;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [3:0]  exp_mbm;
  } vec_t;

  vec_t vecs[9];

  // One transaction from IDLE. Request is driven in cycle 0; grant must
  // show on the memory side in cycle 1 and the ack arrive lat+1 cycles later
  // (TO_CYC cycles later on a timeout).
  task automatic do_txn(input int id, input vec_t v);
    int rise, ack_c, hi_cnt, exp_ack;
    bit got, bad_hold, bad_stall;
    rise = -1; ack_c = -1; hi_cnt = 0; got = 0; bad_hold = 0; bad_stall = 0;
    exp_ack = (v.lat >= 0) ? v.lat + 1 : TO_CYC;
    @(posedge tb_clk);
    #1;
    mem_lat = v.lat;
    exp_q.push_back({v.is_lsu & v.we, v.addr});
    if (v.is_lsu) begin
      lsu_req = 1'b1; lsu_we = v.we; lsu_addr = v.addr;
      lsu_wdata = v.wdata; lsu_bmask = v.bmask;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge tb_clk);
      if (mem_req) begin
        hi_cnt++;
        if (rise < 0) rise = c;
        if (mem_addr !== v.addr || mem_bmask !== v.exp_mbm || mem_we !== (v.is_lsu & v.we))
          bad_hold = 1;
        if (v.is_lsu && v.we && mem_wdata !== v.wdata) bad_hold = 1;
      end
      if (v.is_lsu ? lsu_ack : if_ack) begin
        got = 1; ack_c = c;
        check($sformatf("v%0d_rdata", id), v.is_lsu ? lsu_rdata : if_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", id), v.is_lsu ? lsu_err : if_err, v.exp_err);
        check($sformatf("v%0d_other_ack", id), v.is_lsu ? if_ack : lsu_ack, 1'b0);
        check($sformatf("v%0d_stall_at_ack", id), v.is_lsu ? lsu_stall : if_stall, 1'b0);
        if (v.is_lsu) lsu_req = 1'b0;
        else if_req = 1'b0;
      end else if ((v.is_lsu ? lsu_stall : if_stall) !== 1'b1) begin
        bad_stall = 1;
      end
    end
    check($sformatf("v%0d_ack_seen", id), got, 1'b1);
    check($sformatf("v%0d_grant_cycle", id), rise, 1);
    check($sformatf("v%0d_ack_cycle", id), ack_c, 1 + exp_ack);
    check($sformatf("v%0d_req_high_cycles", id), hi_cnt, exp_ack);
    check($sformatf("v%0d_cmd_stable", id), bad_hold, 1'b0);
    check($sformatf("v%0d_stall_until_ack", id), bad_stall, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lsu_c, if_c, lsu_n, if_at, late_acks;
    bit stall_bad;

    tb_rst = 1'b1;
    if_req = 0; if_addr = '0;
    lsu_req = 0; lsu_we = 0; lsu_addr = '0; lsu_wdata = '0; lsu_bmask = '0;
    mem_lat = -1; inject_ack = 0;

    mem_model[32'h10]  = 32'h0230_0093;
    mem_model[32'h24]  = 32'h0050_0113;
    mem_model[32'h304] = 32'hCAFE_F00D;
    mem_model[32'h13]  = 32'h0BAD_F00D;
    mem_model[32'h200] = 32'hDEAD_BEEF;
    mem_model[32'h40]  = 32'h1234_5678;
    mem_model[32'h50]  = 32'h00A0_0513;

    vecs[0] = '{is_lsu:0, we:0, addr:32'h10,  wdata:0, bmask:0, lat:2,  exp_rdata:32'h0230_0093, exp_err:0, exp_mbm:0};
    vecs[1] = '{is_lsu:0, we:0, addr:32'h24,  wdata:0, bmask:0, lat:1,  exp_rdata:32'h0050_0113, exp_err:0, exp_mbm:0};
    vecs[2] = '{is_lsu:1, we:1, addr:32'h300, wdata:32'h1122_3344, bmask:4'hF, lat:3, exp_rdata:0, exp_err:0, exp_mbm:4'hF};
    vecs[3] = '{is_lsu:1, we:0, addr:32'h300, wdata:0, bmask:0, lat:1,  exp_rdata:32'h1122_3344, exp_err:0, exp_mbm:0};
    vecs[4] = '{is_lsu:1, we:0, addr:32'h304, wdata:32'h5555_5555, bmask:4'hF, lat:4, exp_rdata:32'hCAFE_F00D, exp_err:0, exp_mbm:0};
    vecs[5] = '{is_lsu:0, we:0, addr:32'h13,  wdata:0, bmask:0, lat:1,  exp_rdata:32'h0BAD_F00D, exp_err:0, exp_mbm:0};
    vecs[6] = '{is_lsu:1, we:1, addr:32'h200, wdata:32'h0000_3058, bmask:4'h3, lat:2, exp_rdata:0, exp_err:0, exp_mbm:4'h3};
    vecs[7] = '{is_lsu:1, we:0, addr:32'h200, wdata:0, bmask:0, lat:2,  exp_rdata:32'hDEAD_3058, exp_err:0, exp_mbm:0};
    vecs[8] = '{is_lsu:1, we:0, addr:32'h204, wdata:0, bmask:0, lat:-1, exp_rdata:32'h0, exp_err:1, exp_mbm:0};

    // Reset state
    repeat (2) @(posedge tb_clk);
    @(negedge tb_clk);
    check("rst_mem_cmd", {mem_req, mem_we, mem_addr, mem_wdata, mem_bmask}, '0);
    check("rst_resp", {if_ack, if_err, lsu_ack, lsu_err, if_stall, lsu_stall}, '0);
    check("rst_rdata", {if_rdata, lsu_rdata}, '0);
    check("rst_state", dbg.state, IDLE);
    check("rst_counters", {dbg.timeout_cnt, dbg.starve_cnt}, '0);
    @(posedge tb_clk);
    #1 tb_rst = 1'b0;

    // Single transactions, ending with the LSU timeout
    for (int i = 0; i < 9; i++) do_txn(i, vecs[i]);

    // A late ack two cycles after the abort must be ignored
    @(negedge tb_clk);
    inject_ack = 1'b1;
    @(negedge tb_clk);
    inject_ack = 1'b0;
    check("late_ack_no_resp", {lsu_ack, lsu_err, if_ack, if_err, mem_req}, '0);
    check("late_ack_state", dbg.state, IDLE);
    @(negedge tb_clk);
    check("late_ack_no_resp_next", {lsu_ack, lsu_err, if_ack, mem_req}, '0);
    check("late_ack_rdata", lsu_rdata, 32'h0);

    // Simultaneous IF fetch and LSU store: LSU first, IF in the next IDLE
    @(posedge tb_clk);
    #1;
    mem_lat = 1;
    exp_q.push_back({1'b1, 32'h200});
    exp_q.push_back({1'b0, 32'h14});
    if_req = 1; if_addr = 32'h14;
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h200; lsu_wdata = 32'h0002_3058; lsu_bmask = 4'hF;
    lsu_c = -1; if_c = -1; stall_bad = 0;
    for (int c = 0; c < 40 && if_c < 0; c++) begin
      @(negedge tb_clk);
      if (c == 1) check("sim_first_grant", {mem_we, mem_addr, mem_bmask}, {1'b1, 32'h200, 4'hF});
      if (lsu_ack) begin lsu_c = c; lsu_req = 0; end
      if (if_ack) begin
        if_c = c; if_req = 0;
        check("sim_if_rdata", if_rdata, 32'h0);
      end else if (if_stall !== 1'b1) begin
        stall_bad = 1;
      end
    end
    check("sim_lsu_ack_cycle", lsu_c, 3);
    check("sim_if_ack_cycle", if_c, 7);
    check("sim_if_stall_held", stall_bad, 1'b0);

    // Starvation: IF held while LSU re-requests after every ack
    @(posedge tb_clk);
    #1;
    mem_lat = 1;
    exp_q.push_back({1'b0, 32'h100});
    exp_q.push_back({1'b0, 32'h104});
    exp_q.push_back({1'b0, 32'h108});
    exp_q.push_back({1'b0, 32'h10C});
    exp_q.push_back({1'b0, 32'h40});
    exp_q.push_back({1'b0, 32'h110});
    if_req = 1; if_addr = 32'h40;
    lsu_req = 1; lsu_we = 0; lsu_addr = 32'h100; lsu_wdata = '0; lsu_bmask = '0;
    lsu_n = 0; if_at = -1;
    for (int c = 0; c < 80 && (if_req || lsu_req); c++) begin
      @(negedge tb_clk);
      if (dbg.state == WAIT_IF && if_at < 0) begin
        if_at = lsu_n;
        check("starve_cnt_cleared", dbg.starve_cnt, 8'd0);
      end
      if (lsu_ack) begin
        lsu_n++;
        if (lsu_n == 5) lsu_req = 0;
        else lsu_addr = lsu_addr + 32'd4;
      end
      if (if_ack) begin
        if_req = 0;
        check("starve_if_rdata", if_rdata, 32'h1234_5678);
      end
      if (lsu_n == 4 && dbg.state == IDLE && if_at < 0)
        check("starve_cnt_at_limit", dbg.starve_cnt, 8'd4);
    end
    check("starve_if_after_lsu", if_at, 4);
    check("starve_total_lsu", lsu_n, 5);

    // Reset in the middle of WAIT_IF
    @(posedge tb_clk);
    #1;
    mem_lat = -1;
    exp_q.push_back({1'b0, 32'h50});
    if_req = 1; if_addr = 32'h50;
    @(negedge tb_clk);
    @(negedge tb_clk);
    check("mid_rst_pre_state", dbg.state, WAIT_IF);
    @(posedge tb_clk);
    #1;
    tb_rst = 1; if_req = 0;
    @(posedge tb_clk);
    #1 tb_rst = 0;
    @(negedge tb_clk);
    check("mid_rst_mem_cmd", {mem_req, mem_we, mem_addr, mem_wdata, mem_bmask}, '0);
    check("mid_rst_resp", {if_ack, if_err, lsu_ack, lsu_err, if_stall, lsu_stall}, '0);
    check("mid_rst_rdata", {if_rdata, lsu_rdata}, '0);
    check("mid_rst_state", dbg.state, IDLE);
    late_acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge tb_clk);
      if (if_ack) late_acks++;
    end
    check("mid_rst_no_if_ack", late_acks, 0);
    do_txn(9, '{is_lsu:0, we:0, addr:32'h50, wdata:0, bmask:0, lat:2,
                exp_rdata:32'h00A0_0513, exp_err:0, exp_mbm:0});

    // Final report
    repeat (3) @(negedge tb_clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters in the 5-stage RV32I pipeline: the IF stage and the MEM-stage load/store unit (LSU).
- A request/ack FSM grants one requester at a time and drives the memory-side handshake, which has variable latency.
- Returns read data and a one-cycle ack to the granted requester, and produces stall signals that the hazard unit consumes.
- Includes a starvation guard for fetch and a timeout abort for a memory that never answers.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- STARVE_LIMIT, 4, number of consecutive LSU grants while IF is waiting before IF is forced to win.
- TIMEOUT, 16, number of cycles in a WAIT state without i_mem_ack before the transaction is aborted.

Ports:
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_if_req  in  1  fetch request; held high until o_if_ack.
- i_if_addr  in  AW  fetch address; stable while i_if_req is high.
- o_if_rdata  out  DW  fetched instruction; valid when o_if_ack=1.
- o_if_ack  out  1  one-cycle completion pulse for fetch.
- o_if_err  out  1  qualifies o_if_ack; the fetch timed out.
- o_if_stall  out  1  i_if_req & ~o_if_ack.
- i_lsu_req  in  1  LSU request; held high until o_lsu_ack.
- i_lsu_we  in  1  1 = store, 0 = load.
- i_lsu_addr  in  AW  LSU address.
- i_lsu_wdata  in  DW  store data.
- i_lsu_bmask  in  4  store byte enables.
- o_lsu_rdata  out  DW  load data (raw word; the LSU does sign/zero extension).
- o_lsu_ack  out  1  one-cycle completion pulse for the LSU.
- o_lsu_err  out  1  qualifies o_lsu_ack; the LSU access timed out.
- o_lsu_stall  out  1  i_lsu_req & ~o_lsu_ack.
- o_mem_req  out  1  memory request; held until the ack cycle, inclusive.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  AW  memory address.
- o_mem_wdata  out  DW  memory write data.
- o_mem_bmask  out  4  memory byte mask; forced to 0 for reads.
- i_mem_rdata  in  DW  memory read data; valid with i_mem_ack.
- i_mem_ack  in  1  memory completion, at least 1 cycle after o_mem_req rises.

Behaviour:
- Reset:
  - All outputs 0, state IDLE, starvation counter and timeout counter 0.
  - Applies mid-transaction: the pending access is discarded, o_mem_req is low after the reset edge, and no ack is issued.
- States: IDLE, WAIT_IF, WAIT_LSU, RESP.
- IDLE arbitration, evaluated each cycle:
  - Only one request high: grant it.
  - Both high: grant LSU, unless the starvation counter equals STARVE_LIMIT, in which case grant IF.
  - Starvation counter increments on each LSU grant made while i_if_req is high, saturates at STARVE_LIMIT, and clears on any IF grant.
- Grant edge:
  - Register the winner's addr/we/wdata/bmask onto the o_mem_* outputs and set o_mem_req=1.
  - Move to WAIT_IF or WAIT_LSU and clear the timeout counter.
  - A fetch is always a read: o_mem_we=0, o_mem_bmask=0.
- WAIT_x:
  - o_mem_* held stable and the timeout counter increments each cycle.
  - On i_mem_ack: capture i_mem_rdata into o_x_rdata (stores capture 0), drop o_mem_req, go to RESP.
  - Timeout counter reaches TIMEOUT-1 with no ack: drop o_mem_req, set o_x_rdata=0, set o_x_err=1, go to RESP.
- RESP:
  - o_x_ack=1 for exactly this cycle, then IDLE.
  - No arbitration happens in RESP, so the requester can drop its req in the same cycle.
- Latency:
  - Request in IDLE at cycle 0 gives o_mem_req=1 from cycle 1.
  - Ack at cycle k (k ≥ 1) gives o_x_ack at cycle k+1.
  - Minimum of 3 cycles per transaction; back-to-back grants are spaced 3 cycles apart.
- i_mem_ack outside a WAIT state (a late ack after timeout, or an ack in IDLE) is ignored.
- A request that drops before its ack is a protocol violation; behaviour is undefined. Simulation asserts flag it.
- Width rules: addresses pass through unmodified; alignment is the LSU's responsibility.
- o_x_err is 0 whenever o_x_ack is 0.

Decomposition:
- Shared package (pipeline_pkg): arb_state_e enum {IDLE, WAIT_IF, WAIT_LSU, RESP} and the mem_req_t struct {we, addr, wdata, bmask}.
- One sub-module: arb_timeout_cnt, a clear/enable saturating counter with an expired output.
  - Instantiated once for the timeout counter.
  - Reused with limit STARVE_LIMIT for the starvation counter.

Test Plan:
1. Fetch only: i_if_req=1, addr=0x10; memory acks 2 cycles after req with rdata 0x02300093.
   - Required: o_if_ack one cycle later with o_if_rdata=0x02300093 and o_if_err=0; o_mem_bmask=0 throughout.
2. Simultaneous requests: IF addr=0x14 and LSU store addr=0x200, wdata=0x00023058, bmask=0xF.
   - Required: LSU granted first (o_mem_we=1, o_mem_addr=0x200); IF granted in the next IDLE; o_if_stall high until its ack.
3. Starvation: IF held continuously while the LSU re-requests immediately after every ack.
   - Required: after 4 LSU grants the 5th grant goes to IF; the counter is then cleared.
4. Timeout: LSU load at addr=0x204 with the memory never acking.
   - Required: o_mem_req drops after 16 WAIT cycles; o_lsu_ack=1, o_lsu_err=1, o_lsu_rdata=0.
   - Required: a late i_mem_ack arriving 2 cycles later is ignored.
5. Reset mid-WAIT_IF: assert i_rst for 1 cycle.
   - Required: all outputs 0 next cycle and no o_if_ack; a re-issued fetch then completes normally.
6. Sub-word store: LSU we=1, addr=0x200, bmask=0x3, wdata=0x00003058.
   - Required: memory side sees bmask=0x3; a following load of 0x200 returns the expected word with o_lsu_ack one cycle after the memory ack.
